// File: rtl/cond_pkg.sv
// Shared condition-code constants, NZCV bit positions and IT-block FSM states
// for the conditional-execution unit and its condition evaluator.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IT_RUN = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: decides whether cond passes
// against an NZCV flag vector. Codes 1110 and 1111 both pass unconditionally.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional execution: NZCV flag register, condition gating of
// write/branch requests, and an IT-block sequencer with per-slot then/else mask.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int         IT_DEPTH = 4,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              Valid,
  input  logic                              Stall,
  input  logic                              PCS,
  input  logic                              RegW,
  input  logic                              MemW,
  input  logic [1:0]                        FlagW,
  input  logic [3:0]                        Cond,
  input  logic [3:0]                        ALUFlags,
  input  logic                              ITStart,
  input  logic [3:0]                        ITCond,
  input  logic [$clog2(IT_DEPTH+1)-1:0]     ITLen,
  input  logic [IT_DEPTH-1:0]               ITMask,
  output logic                              PCSrc,
  output logic                              RegWrite,
  output logic                              MemWrite,
  output logic                              CondEx,
  output logic [3:0]                        Flags,
  output logic                              ITActive,
  output logic [$clog2(IT_DEPTH+1)-1:0]     ITLeft,
  output logic                              ITErr
);

  localparam int LW = $clog2(IT_DEPTH + 1);

  it_state_e           state;
  logic [IT_DEPTH-1:0] mask;
  logic [3:0]          it_cond;
  logic [LW-1:0]       it_left;
  logic [3:0]          flags;
  logic                it_err;

  logic       accept;
  logic       in_run;
  logic       else_slot;
  logic       len_ok;
  logic       wr_en;
  logic [3:0] eff_cond;
  logic       cond_pass;

  assign accept    = Valid & ~Stall;
  assign in_run    = (state == IT_RUN);
  assign else_slot = in_run & ~mask[0];
  assign len_ok    = (ITLen != '0) && (ITLen <= LW'(IT_DEPTH));

  // Inside an IT block the instruction's own Cond is ignored; else-slots run
  // on the inverted base condition (AL inverts to NV, which still passes).
  always_comb begin
    eff_cond = Cond;
    if (in_run)
      eff_cond = mask[0] ? it_cond : {it_cond[3:1], ~it_cond[0]};
  end

  cond_eval u_cond_eval (
    .cond  (eff_cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign CondEx   = cond_pass;
  assign wr_en    = Valid & cond_pass & ~ITStart;
  assign PCSrc    = wr_en & PCS;
  assign RegWrite = wr_en & RegW;
  assign MemWrite = wr_en & MemW;
  assign Flags    = flags;
  assign ITActive = in_run;
  assign ITLeft   = it_left;
  assign ITErr    = it_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      mask    <= '0;
      it_cond <= '0;
      it_left <= '0;
      flags   <= FLAG_RST;
      it_err  <= 1'b0;
    end else begin
      it_err <= 1'b0;
      if (accept) begin
        if (cond_pass && FlagW[1]) flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
        if (cond_pass && FlagW[0]) flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        if (!in_run) begin
          if (ITStart) begin
            if (len_ok) begin
              state   <= IT_RUN;
              it_left <= ITLen;
              mask    <= ITMask;
              it_cond <= ITCond;
            end else begin
              it_err <= 1'b1;
            end
          end
        end else begin
          // A nested IT consumes its slot like any other instruction.
          if (ITStart || (else_slot && it_cond == COND_AL)) it_err <= 1'b1;
          if (PCSrc) begin
            state   <= IDLE;
            it_left <= '0;
            mask    <= '0;
          end else begin
            it_left <= it_left - 1'b1;
            mask    <= mask >> 1;
            if (it_left == LW'(1)) state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit: flag updates, condition gating, IT blocks,
// error pulses, stall and reset, with hand-computed expected values.
module tb_cond_exec_unit;

  localparam int IT_DEPTH = 4;
  localparam int LW = $clog2(IT_DEPTH + 1);

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                Valid, Stall, PCS, RegW, MemW;
  logic [1:0]          FlagW;
  logic [3:0]          Cond, ALUFlags, ITCond;
  logic                ITStart;
  logic [LW-1:0]       ITLen;
  logic [IT_DEPTH-1:0] ITMask;
  logic                PCSrc, RegWrite, MemWrite, CondEx, ITActive, ITErr;
  logic [3:0]          Flags;
  logic [LW-1:0]       ITLeft;

  int vectors = 0;
  int miscompares = 0;

  cond_exec_unit #(.IT_DEPTH(IT_DEPTH), .FLAG_RST(4'b0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .Valid(Valid), .Stall(Stall), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags),
    .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITMask(ITMask),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .ITActive(ITActive), .ITLeft(ITLeft), .ITErr(ITErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    Valid = 0; Stall = 0; PCS = 0; RegW = 0; MemW = 0; FlagW = 2'b00;
    Cond = 4'b1110; ALUFlags = 4'b0000; ITStart = 0; ITCond = 4'b0000;
    ITLen = '0; ITMask = '0;
  endtask

  initial begin
    clr();
    RST_N = 0;
    tick(); tick();
    RST_N = 1;
    #1;
    chk("rst_flags", 8'(Flags), 8'h0);
    chk("rst_itactive", 8'(ITActive), 8'h0);
    chk("rst_itleft", 8'(ITLeft), 8'h0);
    chk("rst_iterr", 8'(ITErr), 8'h0);

    // EQ fails with Z=0 in reset flags
    clr(); Valid = 1; Cond = 4'b0000; RegW = 1; #1;
    chk("eq_fail_regwrite", 8'(RegWrite), 8'h0);
    chk("eq_fail_condex", 8'(CondEx), 8'h0);
    tick();
    clr(); Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    chk("al_flagwr_regwrite", 8'(RegWrite), 8'h0);
    chk("no_bypass_flags", 8'(Flags), 8'h0);
    tick();
    clr(); Valid = 1; Cond = 4'b0000; RegW = 1; #1;
    chk("eq_pass_regwrite", 8'(RegWrite), 8'h1);
    chk("eq_pass_flags", 8'(Flags), 8'h4);
    Valid = 0; #1;
    chk("novalid_regwrite", 8'(RegWrite), 8'h0);
    tick();

    // NZ-only update and stall freeze
    clr(); Valid = 1; FlagW = 2'b11; ALUFlags = 4'b0000; tick();
    chk("flags_cleared", 8'(Flags), 8'h0);
    clr(); Valid = 1; Stall = 1; FlagW = 2'b10; ALUFlags = 4'b1111; RegW = 1; #1;
    chk("stall_regwrite", 8'(RegWrite), 8'h1);
    tick();
    chk("stall_flags_hold", 8'(Flags), 8'h0);
    Stall = 0; RegW = 0; tick();
    chk("nz_update", 8'(Flags), 8'hC);
    clr(); Valid = 1; FlagW = 2'b01; ALUFlags = 4'b0011; tick();
    chk("cv_update", 8'(Flags), 8'hF);

    // Condition decode against NZCV=1111
    clr(); Valid = 1; Cond = 4'b1100; #1; chk("gt_1111", 8'(CondEx), 8'h0);
    Cond = 4'b1010; #1; chk("ge_1111", 8'(CondEx), 8'h1);
    Cond = 4'b1000; #1; chk("hi_1111", 8'(CondEx), 8'h0);
    Cond = 4'b1001; #1; chk("ls_1111", 8'(CondEx), 8'h1);
    Cond = 4'b1111; #1; chk("nv_1111", 8'(CondEx), 8'h1);
    Cond = 4'b0011; #1; chk("cc_1111", 8'(CondEx), 8'h0);

    // IT EQ, len 3, mask then/else/then, with a stall in slot 1
    clr(); Valid = 1; ITStart = 1; ITCond = 4'b0000; ITLen = 3; ITMask = 4'b1101; MemW = 1; #1;
    chk("it_instr_memwrite", 8'(MemWrite), 8'h0);
    tick();
    chk("it_active", 8'(ITActive), 8'h1);
    clr(); Valid = 1; ITCond = 4'b0000; Cond = 4'b0001; MemW = 1; #1;
    chk("slot0_itleft", 8'(ITLeft), 8'h3);
    chk("slot0_memwrite", 8'(MemWrite), 8'h1);
    tick();
    Stall = 1; tick();
    chk("slot1_stall_itleft", 8'(ITLeft), 8'h2);
    Stall = 0; #1;
    chk("slot1_memwrite", 8'(MemWrite), 8'h0);
    tick();
    chk("slot2_itleft", 8'(ITLeft), 8'h1);
    chk("slot2_memwrite", 8'(MemWrite), 8'h1);
    tick();
    chk("it_done_active", 8'(ITActive), 8'h0);
    chk("it_done_itleft", 8'(ITLeft), 8'h0);
    #1; chk("idle_ne_memwrite", 8'(MemWrite), 8'h0);

    // Branch inside IT block aborts it
    clr(); Valid = 1; ITStart = 1; ITCond = 4'b1110; ITLen = 3; ITMask = 4'b0111; tick();
    chk("br_it_itleft", 8'(ITLeft), 8'h3);
    clr(); Valid = 1; ITCond = 4'b1110; PCS = 1; #1;
    chk("br_pcsrc", 8'(PCSrc), 8'h1);
    tick();
    chk("br_abort_active", 8'(ITActive), 8'h0);
    chk("br_abort_itleft", 8'(ITLeft), 8'h0);

    // Else-slot of an AL block: error pulse, still executes
    clr(); Valid = 1; ITStart = 1; ITCond = 4'b1110; ITLen = 1; ITMask = 4'b0000; tick();
    clr(); Valid = 1; ITCond = 4'b1110; RegW = 1; #1;
    chk("al_else_regwrite", 8'(RegWrite), 8'h1);
    tick();
    chk("al_else_iterr", 8'(ITErr), 8'h1);
    chk("al_else_active", 8'(ITActive), 8'h0);
    clr(); tick();
    chk("iterr_one_cycle", 8'(ITErr), 8'h0);

    // Illegal IT lengths
    clr(); Valid = 1; ITStart = 1; ITLen = 5; ITMask = 4'b1111; tick();
    chk("len5_iterr", 8'(ITErr), 8'h1);
    chk("len5_active", 8'(ITActive), 8'h0);
    clr(); Valid = 1; ITStart = 1; ITLen = 0; tick();
    chk("len0_iterr", 8'(ITErr), 8'h1);
    chk("len0_active", 8'(ITActive), 8'h0);

    // Reset in the middle of an IT block
    clr(); Valid = 1; FlagW = 2'b11; ALUFlags = 4'b1010; tick();
    chk("flags_1010", 8'(Flags), 8'hA);
    clr(); Valid = 1; ITStart = 1; ITCond = 4'b1110; ITLen = 2; ITMask = 4'b0011; tick();
    chk("mid_it_itleft", 8'(ITLeft), 8'h2);
    clr(); RST_N = 0; Valid = 1; ITCond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0101; tick();
    chk("rst_mid_flags", 8'(Flags), 8'h0);
    chk("rst_mid_active", 8'(ITActive), 8'h0);
    chk("rst_mid_itleft", 8'(ITLeft), 8'h0);
    RST_N = 1;
    clr(); Valid = 1; Cond = 4'b0001; PCS = 1; RegW = 1; MemW = 1; #1;
    chk("post_rst_outs", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h7);
    Cond = 4'b0000; #1;
    chk("post_rst_eq_outs", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h0);
    tick();

    // Nested IT start consumes a slot and flags an error
    clr(); Valid = 1; ITStart = 1; ITCond = 4'b1110; ITLen = 2; ITMask = 4'b0011; tick();
    chk("nest_itleft0", 8'(ITLeft), 8'h2);
    ITLen = 4; #1;
    chk("nest_memwrite", 8'(MemWrite), 8'h0);
    tick();
    chk("nest_iterr", 8'(ITErr), 8'h1);
    chk("nest_itleft1", 8'(ITLeft), 8'h1);
    chk("nest_active", 8'(ITActive), 8'h1);
    clr(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 SHALL have parameter IT_DEPTH, default 4, max instructions in a predicated (IT) block, legal range 1..8.
REQ-002 SHALL have parameter FLAG_RST, default 4'b0000, reset value of NZCV flag register.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports in REQ-004..005.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  in  1  synchronous active-low reset.
REQ-006 Valid  in  1  execute-stage instruction present.
REQ-007 Stall  in  1  execute stage held; no state change.
REQ-008 PCS, RegW, MemW  in  1 each  decoder write/branch requests.
REQ-009 FlagW  in  2  [1]=update N,Z; [0]=update C,V.
REQ-010 Cond  in  4  instruction condition field (ARM encoding).
REQ-011 ALUFlags  in  4  NZCV from ALU, bit3=N.
REQ-012 ITStart  in  1  current instruction is an IT instruction.
REQ-013 ITCond  in  4  IT base condition; ITLen  in  $clog2(IT_DEPTH+1)  block length; ITMask  in  IT_DEPTH  bit i=1 then, 0 else, for slot i.
REQ-014 PCSrc, RegWrite, MemWrite  out  1 each  gated requests.
REQ-015 CondEx  out  1  effective condition passed.
REQ-016 Flags  out  4  registered NZCV.
REQ-017 ITActive  out  1  FSM in IT_RUN; ITLeft  out  $clog2(IT_DEPTH+1)  slots remaining.
REQ-018 ITErr  out  1  one-cycle pulse on illegal IT event.

Function
REQ-019 Accept = Valid & ~Stall; all registered updates SHALL occur only on an accept cycle.
REQ-020 Effective condition SHALL be Cond in IDLE; in IT_RUN, ITCond if current mask bit=1, else ITCond with bit0 inverted.
REQ-021 CondEx SHALL be evaluated combinationally against registered Flags (no same-cycle ALUFlags bypass); codes 1110 and 1111 SHALL evaluate true.
REQ-022 PCSrc/RegWrite/MemWrite SHALL equal Valid & CondEx & PCS/RegW/MemW, zero-latency; all SHALL be 0 for an IT instruction itself.
REQ-023 Flags[3:2] SHALL load ALUFlags[3:2] on accept & CondEx & FlagW[1]; Flags[1:0] likewise with FlagW[0]; otherwise hold.
REQ-024 FSM states IDLE, IT_RUN only.
REQ-025 IDLE->IT_RUN on accept & ITStart & 1<=ITLen<=IT_DEPTH: load ITLeft=ITLen, mask shift register=ITMask.
REQ-026 IT_RUN: each accept consumes one slot (ITLeft-1, mask shifts right); ITLeft 1->0 returns to IDLE next edge.
REQ-027 IT_RUN: accept with PCSrc=1 SHALL abort to IDLE, ITLeft=0 (branch flush).
REQ-028 ITStart in IT_RUN SHALL be treated as no-op slot consumer, pulse ITErr, not reload.
REQ-029 ITStart with ITLen=0 or >IT_DEPTH SHALL pulse ITErr, stay IDLE.
REQ-030 Else-slot with ITCond=1110 SHALL pulse ITErr and execute as always-true.
REQ-031 Stall=1 SHALL freeze Flags, FSM, ITLeft, mask; outputs still follow REQ-022 combinationally.
REQ-032 Valid=0 SHALL force all write/branch outputs 0 and consume no slot.

Reset
REQ-033 On RST_N=0 at rising edge: Flags=FLAG_RST, state=IDLE, ITLeft=0, mask=0, ITErr=0; reset overrides accept, including mid-IT-block.

Structure
REQ-034 Shared package cond_pkg SHALL hold 4-bit condition-code constants, NZCV bit indices and the FSM state enum.
REQ-035 One combinational sub-module cond_eval (cond, flags -> pass) SHALL be used; FSM, mask register and flag register live in the top.

Verification
REQ-036 Reset, then Valid=1 Cond=0000(EQ) RegW=1 -> RegWrite=0; prior cycle ALU write FlagW=11 ALUFlags=0100 -> next cycle RegWrite=1, Flags=0100.
REQ-037 FlagW=10, ALUFlags=1111, Flags=0000 -> Flags=1100; with Stall=1 same stimulus -> Flags unchanged.
REQ-038 ITStart ITCond=0000 ITLen=3 ITMask=x101, Z=1, three valid MemW=1 instructions -> MemWrite 1,0,1; ITLeft 3,2,1; IDLE after third.
REQ-039 IT_RUN ITLeft=3, slot1 PCS=1 passing -> PCSrc=1, next cycle ITActive=0, ITLeft=0.
REQ-040 ITStart ITLen=5 (IT_DEPTH=4) -> ITErr one cycle, ITActive stays 0; ITStart during IT_RUN -> ITErr, ITLeft decrements by 1.
REQ-041 RST_N=0 asserted at ITLeft=2 with Flags=1010 -> next edge Flags=0000, ITActive=0, all outputs per REQ-022 in IDLE.
